// File: rtl/dev_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// dev_bus_arbiter_if
// Purpose : groups the two master request ports, the single device-bus
//           master port and the status output of dev_bus_arbiter.
// Signals :
//   m0_req/m1_req, m0_addr/m1_addr, m0_we/m1_we, m0_wd/m1_wd  master requests
//   m0_gnt/m1_gnt, m0_done/m1_done, rdata                     master responses
//   bus_addr, bus_we, bus_wd                                  device-bus drive
//   bus_rd                                                    bridge read data
//   busy                                                      arbiter not idle
// Modports:
//   master : the environment side (masters plus device bridge)
//   slave  : the arbiter side
// ---------------------------------------------------------------------------
interface dev_bus_arbiter_if;
    logic        m0_req;
    logic        m1_req;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic        m0_we;
    logic        m1_we;
    logic [31:0] m0_wd;
    logic [31:0] m1_wd;
    logic        m0_gnt;
    logic        m1_gnt;
    logic        m0_done;
    logic        m1_done;
    logic [31:0] rdata;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wd;
    logic [31:0] bus_rd;
    logic        busy;

    modport master (
        output m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_wd, m1_wd,
        output bus_rd,
        input  m0_gnt, m1_gnt, m0_done, m1_done, rdata,
        input  bus_addr, bus_we, bus_wd, busy
    );

    modport slave (
        input  m0_req, m1_req, m0_addr, m1_addr, m0_we, m1_we, m0_wd, m1_wd,
        input  bus_rd,
        output m0_gnt, m1_gnt, m0_done, m1_done, rdata,
        output bus_addr, bus_we, bus_wd, busy
    );
endinterface

// File: rtl/dev_bus_arbiter.sv
// ---------------------------------------------------------------------------
// dev_bus_arbiter
// Purpose : arbitrates two masters (m0 = CPU, m1 = DMA/debug) onto a single
//           device-bus master port. Each transaction is IDLE -> ACCESS (one
//           cycle on the device bus) -> DONE (one-cycle done strobe with
//           read data) -> IDLE.
// Ports   :
//   clk   in  system clock, all state on rising edge
//   reset in  asynchronous, active-low reset
//   ifc   dev_bus_arbiter_if.slave (requests, grants, done, rdata, device
//         bus drive, bridge read data, busy)
// Config  : DEV_ARB_RR_EN defined   -> simultaneous requests go to the master
//                                      not granted last (round robin)
//           DEV_ARB_RR_EN undefined -> m0 always wins simultaneous requests
// ---------------------------------------------------------------------------
module dev_bus_arbiter (
    input logic               clk,
    input logic               reset,
    dev_bus_arbiter_if.slave  ifc
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_owner;
    logic        r_m0Gnt;
    logic        r_m1Gnt;
    logic        r_m0Done;
    logic        r_m1Done;
    logic        r_busy;
    logic        r_busWe;
    logic [31:0] r_busAddr;
    logic [31:0] r_busWd;
    logic [31:0] r_rdata;

    logic        w_anyReq;
    logic        w_winner;

    assign w_anyReq = ifc.m0_req | ifc.m1_req;

    // w_winner is the id of the master that gets the next grant; it is only
    // meaningful while w_anyReq is high.
`ifdef DEV_ARB_RR_EN
    logic r_lastGnt;
    assign w_winner = (ifc.m0_req & ifc.m1_req) ? ~r_lastGnt : ifc.m1_req;
`else
    assign w_winner = ~ifc.m0_req;
`endif

    // The device-bus registers double as the request latch: they are loaded
    // from the winner at the grant edge and cleared at the edge that closes
    // ACCESS, so later changes on the master ports cannot reach the bus.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_owner   <= 1'b0;
            r_m0Gnt   <= 1'b0;
            r_m1Gnt   <= 1'b0;
            r_m0Done  <= 1'b0;
            r_m1Done  <= 1'b0;
            r_busy    <= 1'b0;
            r_busWe   <= 1'b0;
            r_busAddr <= 32'h0;
            r_busWd   <= 32'h0;
            r_rdata   <= 32'h0;
`ifdef DEV_ARB_RR_EN
            r_lastGnt <= 1'b1;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_state   <= ACCESS;
                        r_owner   <= w_winner;
                        r_m0Gnt   <= ~w_winner;
                        r_m1Gnt   <= w_winner;
                        r_busy    <= 1'b1;
                        r_busAddr <= w_winner ? ifc.m1_addr : ifc.m0_addr;
                        r_busWe   <= w_winner ? ifc.m1_we   : ifc.m0_we;
                        r_busWd   <= w_winner ? ifc.m1_wd   : ifc.m0_wd;
`ifdef DEV_ARB_RR_EN
                        r_lastGnt <= w_winner;
`endif
                    end
                end
                ACCESS: begin
                    r_state   <= DONE;
                    r_rdata   <= ifc.bus_rd;
                    r_busWe   <= 1'b0;
                    r_busAddr <= 32'h0;
                    r_busWd   <= 32'h0;
                    r_m0Done  <= ~r_owner;
                    r_m1Done  <= r_owner;
                end
                DONE: begin
                    r_state  <= IDLE;
                    r_m0Gnt  <= 1'b0;
                    r_m1Gnt  <= 1'b0;
                    r_m0Done <= 1'b0;
                    r_m1Done <= 1'b0;
                    r_busy   <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ifc.m0_gnt   = r_m0Gnt;
    assign ifc.m1_gnt   = r_m1Gnt;
    assign ifc.m0_done  = r_m0Done;
    assign ifc.m1_done  = r_m1Done;
    assign ifc.rdata    = r_rdata;
    assign ifc.bus_addr = r_busAddr;
    assign ifc.bus_we   = r_busWe;
    assign ifc.bus_wd   = r_busWd;
    assign ifc.busy     = r_busy;

endmodule

// File: tb/tb_dev_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dev_bus_arbiter
// Purpose : self-checking bench for dev_bus_arbiter. A transaction-level
//           model predicts every output each cycle; directed scenarios add
//           hand-computed literal expectations. Compile with +define+
//           DEV_ARB_RR_EN to exercise the round-robin build.
// ---------------------------------------------------------------------------
module tb_dev_bus_arbiter;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    dev_bus_arbiter_if intf();

    dev_bus_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (intf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transaction-level model: a transaction is granted at the edge where the
    // arbiter is free and a request is present, spends one cycle on the bus,
    // one cycle signalling done, then the arbiter is free again.
    bit          mBusy;
    int          mAge;
    int          mOwner;
    int          mLast;
    logic [31:0] mAddr;
    logic [31:0] mWd;
    logic        mWe;
    logic [31:0] mRdata;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mBusy  = 1'b0;
            mAge   = 0;
            mOwner = 0;
            mLast  = 1;
            mRdata = 32'h0;
        end else if (mBusy && mAge == 1) begin
            mBusy = 1'b0;
        end else if (mBusy) begin
            mAge   = 1;
            mRdata = intf.bus_rd;
        end else if (intf.m0_req || intf.m1_req) begin
            if (intf.m0_req && intf.m1_req) begin
`ifdef DEV_ARB_RR_EN
                mOwner = 1 - mLast;
`else
                mOwner = 0;
`endif
            end else begin
                mOwner = intf.m1_req ? 1 : 0;
            end
            mLast = mOwner;
            mAddr = (mOwner == 1) ? intf.m1_addr : intf.m0_addr;
            mWe   = (mOwner == 1) ? intf.m1_we   : intf.m0_we;
            mWd   = (mOwner == 1) ? intf.m1_wd   : intf.m0_wd;
            mBusy = 1'b1;
            mAge  = 0;
        end
    end

    // Per-cycle comparison of all outputs against the model.
    always @(posedge clk) begin
        logic [101:0] expV;
        logic [101:0] actV;
        logic         onBus;
        #1;
        onBus = mBusy && (mAge == 0);
        expV = {mBusy && mOwner == 0, mBusy && mOwner == 1,
                mBusy && mAge == 1 && mOwner == 0, mBusy && mAge == 1 && mOwner == 1,
                mBusy, onBus ? mWe : 1'b0,
                onBus ? mAddr : 32'h0, onBus ? mWd : 32'h0, mRdata};
        actV = {intf.m0_gnt, intf.m1_gnt, intf.m0_done, intf.m1_done,
                intf.busy, intf.bus_we, intf.bus_addr, intf.bus_wd, intf.rdata};
        compared++;
        if (actV !== expV) begin
            mismatched++;
            $display("[TB] FAIL cycleModel t=%0t got gnt/done/busy/we=%b addr=%h wd=%h rdata=%h expected gnt/done/busy/we=%b addr=%h wd=%h rdata=%h",
                     $time, actV[101:96], actV[95:64], actV[63:32], actV[31:0],
                     expV[101:96], expV[95:64], expV[63:32], expV[31:0]);
        end
    end

    // Literal comparison with the shared counters.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Drive one master's request fields at the falling edge.
    task automatic applyStimulus(input int m, input logic req, input logic [31:0] addr,
                                 input logic we, input logic [31:0] wd);
        @(negedge clk);
        if (m == 0) begin
            intf.m0_req = req; intf.m0_addr = addr; intf.m0_we = we; intf.m0_wd = wd;
        end else begin
            intf.m1_req = req; intf.m1_addr = addr; intf.m1_we = we; intf.m1_wd = wd;
        end
    endtask

    task automatic waitEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    logic expW [4];
    logic gotW [4];

    initial begin
        compared   = 0;
        mismatched = 0;
        reset = 1'b0;
        intf.m0_req = 1'b0; intf.m0_addr = 32'h0; intf.m0_we = 1'b0; intf.m0_wd = 32'h0;
        intf.m1_req = 1'b0; intf.m1_addr = 32'h0; intf.m1_we = 1'b0; intf.m1_wd = 32'h0;
        intf.bus_rd = 32'h0;
`ifdef DEV_ARB_RR_EN
        expW[0] = 1'b0; expW[1] = 1'b1; expW[2] = 1'b0; expW[3] = 1'b1;
`else
        expW[0] = 1'b0; expW[1] = 1'b0; expW[2] = 1'b0; expW[3] = 1'b0;
`endif

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rstBusy",  {31'h0, intf.busy},   32'h0);
        checkOutput("rstAddr",  intf.bus_addr,        32'h0);
        checkOutput("rstRdata", intf.rdata,           32'h0);
        reset = 1'b1;

        // m0 read
        intf.bus_rd = 32'h0000_1234;
        applyStimulus(0, 1'b1, 32'h0000_7F04, 1'b0, 32'h0);
        waitEdge();
        checkOutput("rdBusAddr", intf.bus_addr, 32'h0000_7F04);
        checkOutput("rdGnt",     {31'h0, intf.m0_gnt}, 32'h1);
        applyStimulus(0, 1'b0, 32'h0000_7F04, 1'b0, 32'h0);
        waitEdge();
        checkOutput("rdDone",  {31'h0, intf.m0_done}, 32'h1);
        checkOutput("rdRdata", intf.rdata, 32'h0000_1234);
        waitEdge();

        // m1 write
        applyStimulus(1, 1'b1, 32'h0000_7F10, 1'b1, 32'hDEAD_BEEF);
        waitEdge();
        checkOutput("wrWe", {31'h0, intf.bus_we}, 32'h1);
        checkOutput("wrWd", intf.bus_wd, 32'hDEAD_BEEF);
        applyStimulus(1, 1'b0, 32'h0000_7F10, 1'b0, 32'h0);
        waitEdge();
        checkOutput("wrWeOff", {31'h0, intf.bus_we}, 32'h0);
        checkOutput("wrDone",  {31'h0, intf.m1_done}, 32'h1);
        waitEdge();

        // Both masters held high for four transactions
        @(negedge clk);
        intf.m0_req = 1'b1; intf.m0_addr = 32'h0000_7F40;
        intf.m1_req = 1'b1; intf.m1_addr = 32'h0000_7F80;
        for (int t = 0; t < 4; t++) begin
            int  n;
            bit  got;
            n = 0;
            got = 1'b0;
            while (!got && n < 12) begin
                waitEdge();
                n++;
                if (intf.m0_gnt || intf.m1_gnt) got = 1'b1;
            end
            checkOutput("gntSeen", {31'h0, got}, 32'h1);
            gotW[t] = intf.m1_gnt;
            waitEdge();
            waitEdge();
        end
        @(negedge clk);
        intf.m0_req = 1'b0;
        intf.m1_req = 1'b0;
        for (int t = 0; t < 4; t++)
            checkOutput($sformatf("bothWinner%0d", t), {31'h0, gotW[t]}, {31'h0, expW[t]});
        waitEdge();

        // m0 drops request and changes address during ACCESS
        applyStimulus(0, 1'b1, 32'h0000_7F00, 1'b0, 32'h0);
        waitEdge();
        intf.m0_req  = 1'b0;
        intf.m0_addr = 32'h0000_7F14;
        checkOutput("latchAddrA", intf.bus_addr, 32'h0000_7F00);
        @(negedge clk);
        checkOutput("latchAddrB", intf.bus_addr, 32'h0000_7F00);
        waitEdge();
        checkOutput("latchDone", {31'h0, intf.m0_done}, 32'h1);
        waitEdge();

        // Reset during a write's ACCESS, m1 pending
        applyStimulus(0, 1'b1, 32'h0000_7F20, 1'b1, 32'h5555_5555);
        waitEdge();
        checkOutput("abortWe", {31'h0, intf.bus_we}, 32'h1);
        intf.m0_req = 1'b0;
        intf.m1_req = 1'b1; intf.m1_addr = 32'h0000_7F30; intf.m1_we = 1'b0;
        #2 reset = 1'b0;
        #1;
        checkOutput("abortWeOff", {31'h0, intf.bus_we}, 32'h0);
        checkOutput("abortBusy",  {31'h0, intf.busy}, 32'h0);
        checkOutput("abortGnt",   {30'h0, intf.m0_gnt, intf.m1_gnt}, 32'h0);
        waitEdge();
        checkOutput("abortNoDone", {30'h0, intf.m0_done, intf.m1_done}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        waitEdge();
        checkOutput("postRstGnt",  {31'h0, intf.m1_gnt}, 32'h1);
        checkOutput("postRstAddr", intf.bus_addr, 32'h0000_7F30);
        applyStimulus(1, 1'b0, 32'h0000_7F30, 1'b0, 32'h0);
        waitEdge();
        checkOutput("postRstDone", {31'h0, intf.m1_done}, 32'h1);
        waitEdge();

        // Ten idle cycles
        for (int i = 0; i < 10; i++) begin
            waitEdge();
            checkOutput("idleBusy", {31'h0, intf.busy},   32'h0);
            checkOutput("idleWe",   {31'h0, intf.bus_we}, 32'h0);
            checkOutput("idleAddr", intf.bus_addr,        32'h0);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dev_bus_arbiter.md
DEV_BUS_ARBITER -- requirements
Module: dev_bus_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: m0_req, m1_req  in  1  access request from master 0 (CPU) and master 1 (DMA/debug).
REQ-004 SHALL have ports: m0_addr, m1_addr  in  32  byte address; m0_we, m1_we  in  1  write enable; m0_wd, m1_wd  in  32  write data.
REQ-005 SHALL have ports: m0_gnt, m1_gnt  out  1  owner of current transaction.
REQ-006 SHALL have ports: m0_done, m1_done  out  1  one-cycle completion strobe; rdata  out  32  read data, valid while done is high.
REQ-007 SHALL have ports: bus_addr  out  32; bus_we  out  1; bus_wd  out  32  single device-bus master port into the device bridge; bus_rd  in  32  bridge read data.
REQ-008 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-009 SHALL implement three states: IDLE, ACCESS, DONE.
REQ-010 IDLE: on a rising edge with any req high, SHALL pick a winner, latch its addr/we/wd and master id, and enter ACCESS; with no req high, stay IDLE.
REQ-011 ACCESS SHALL last exactly one cycle: bus_addr/bus_wd driven from the latched values, bus_we equal to the latched we; bus_rd captured into rdata at the closing edge; next state DONE.
REQ-012 DONE SHALL last exactly one cycle: the owner's done is high and rdata is valid; next state IDLE unconditionally.
REQ-013 Latency: a req sampled at edge k gives ACCESS in cycle k+1 and done in cycle k+2; minimum request-to-request spacing is 3 cycles.
REQ-014 gnt of the owner SHALL be high during ACCESS and DONE only; at most one gnt high at any time.
REQ-015 Outside ACCESS, bus_we SHALL be 0 and bus_addr and bus_wd SHALL be 32'h0.
REQ-016 A req deasserted during ACCESS/DONE SHALL NOT abort the transaction; the access completes and done still pulses.
REQ-017 A req still high in the first IDLE cycle after DONE SHALL be treated as a new request.
REQ-018 Changes to a master's addr/we/wd after the IDLE sampling edge SHALL NOT affect the in-flight transaction.
REQ-019 A write transaction SHALL produce exactly one bus_we cycle; rdata during a write's DONE is the captured bus_rd value and carries no meaning.
REQ-020 rdata SHALL hold its last captured value outside DONE.

Reset
REQ-021 reset low SHALL immediately force state IDLE, all gnt/done/busy/bus_we to 0, bus_addr/bus_wd/rdata to 32'h0, and last-granted pointer to master 1.
REQ-022 Reset asserted mid-ACCESS SHALL drop bus_we in the same cycle, and no done SHALL be issued for the aborted transaction.
REQ-023 After reset release, the first arbitration SHALL occur at the first rising edge with reset high.

Configuration
REQ-024 Macro DEV_ARB_RR_EN defined: on simultaneous requests the master not granted last wins; the pointer updates on every grant.
REQ-025 DEV_ARB_RR_EN undefined: m0 always wins simultaneous requests; the pointer is not implemented.

Verification
REQ-026 m0 read, addr 32'h7F04, bus_rd=32'h0000_1234 -> bus_addr=32'h7F04 for one cycle; m0_done with rdata=32'h1234 two cycles after sampling.
REQ-027 m1 write, addr 32'h7F10, wd 32'hDEAD_BEEF -> exactly one cycle bus_we=1 with bus_wd=32'hDEADBEEF; m1_done one cycle later.
REQ-028 Both req held high for 4 transactions, RR build -> grants m0,m1,m0,m1; non-RR build -> m0,m0,m0,m0.
REQ-029 m0 drops req and changes m0_addr to 32'h7F14 during ACCESS -> bus_addr stays at the latched 32'h7F00; m0_done still pulses.
REQ-030 reset low during a write's ACCESS -> bus_we=0 immediately, no done issued; after release, pending m1_req is granted first.
REQ-031 No req for 10 cycles -> busy=0, bus_we=0, bus_addr=32'h0 throughout.
